// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: format codes, FSM states and field positions shared by the encoder
package instr_encoder_pkg;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILL} fmt_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int OPC_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SHAMT_LSB = 6;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: load control, field-tuple input and packed-word output handshakes
interface instr_encoder_if #(parameter int CNT_W = 10);
  logic start;
  logic [31:0] base_addr;
  logic [CNT_W-1:0] num_words;
  logic in_valid;
  logic in_ready;
  logic [1:0] fmt;
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [5:0] funct;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic busy;
  logic done;
  logic fmt_err;
  modport master (
    output start, base_addr, num_words, in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26, out_ready,
    input in_ready, out_valid, out_addr, out_data, busy, done, fmt_err
  );
  modport slave (
    input start, base_addr, num_words, in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26, out_ready,
    output in_ready, out_valid, out_addr, out_data, busy, done, fmt_err
  );
endinterface

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational packing of instruction fields into a 32-bit word by format
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input logic [1:0] fmt,
  input logic [5:0] opcode,
  input logic [4:0] rs,
  input logic [4:0] rt,
  input logic [4:0] rd,
  input logic [4:0] shamt,
  input logic [5:0] funct,
  input logic [15:0] imm16,
  input logic [25:0] imm26,
  output logic [31:0] word
);
  logic [31:0] w_r, w_i, w_j;
  always_comb begin
    w_j = (32'(opcode) << OPC_LSB) | 32'(imm26);
    w_i = (32'(opcode) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm16);
    w_r = (32'(opcode) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
          (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | 32'(funct);
    word = fmt == FMT_R ? w_r : fmt == FMT_I ? w_i : fmt == FMT_J ? w_j : '0;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams packed instruction words with incrementing byte addresses for a program load
module instr_encoder
  import instr_encoder_pkg::*;
#(parameter int CNT_W = 10) (
  input logic clk,
  input logic rst_n,
  instr_encoder_if.slave bus
);
  state_t state, state_nxt;
  logic [31:0] addr, word;
  logic [CNT_W-1:0] acc_left, out_left;
  logic acc, load, fire;
  instr_field_pack u_pack (
    .fmt(bus.fmt),
    .opcode(bus.opcode),
    .rs(bus.rs),
    .rt(bus.rt),
    .rd(bus.rd),
    .shamt(bus.shamt),
    .funct(bus.funct),
    .imm16(bus.imm16),
    .imm26(bus.imm26),
    .word(word)
  );
  assign bus.in_ready = state == RUN && acc_left != '0 && (!bus.out_valid || bus.out_ready);
  assign acc = bus.in_valid && bus.in_ready;
  assign load = acc && bus.fmt != FMT_ILL;
  assign fire = bus.out_valid && bus.out_ready;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (bus.start ? (bus.num_words != '0 ? RUN : DONE) : IDLE) :
                state == RUN ? (fire && out_left == CNT_W'(1) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr <= '0;
      acc_left <= '0;
      out_left <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_addr <= '0;
      bus.fmt_err <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        addr <= bus.base_addr;
        acc_left <= bus.num_words;
        out_left <= bus.num_words;
        bus.fmt_err <= 1'b0;
      end
      if (load) begin
        addr <= addr + 32'd4;
        acc_left <= acc_left - CNT_W'(1);
        bus.out_data <= word;
        bus.out_addr <= addr;
      end
      if (acc && !load) bus.fmt_err <= 1'b1;
      if (fire) out_left <= out_left - CNT_W'(1);
      bus.out_valid <= load || (bus.out_valid && !bus.out_ready);
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter CNT_W, default 10: width of the word-count input and the internal counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  one-cycle pulse; begins a program load.
REQ-005 base_addr  input  32  byte address of the first word; latched on start.
REQ-006 num_words  input  CNT_W  number of words to emit; latched on start.
REQ-007 in_valid / in_ready  input / output  1 / 1  field-tuple handshake.
REQ-008 fmt  input  2  instruction format: 0 = R, 1 = I, 2 = J, 3 = illegal.
REQ-009 opcode 6, rs 5, rt 5, rd 5, shamt 5, funct 6, imm16 16, imm26 26  inputs  instruction fields.
REQ-010 out_valid / out_ready  output / input  1 / 1  packed-word handshake to the memory writer.
REQ-011 out_addr  output  32  byte address of the word in out_data.
REQ-012 out_data  output  32  packed instruction word.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse when the last word is accepted downstream.
REQ-015 fmt_err  output  1  sticky flag: an illegal fmt was received; cleared on start.

Function
REQ-016 Packing rules:
- R-type: {opcode, rs, rt, rd, shamt, funct}.
- I-type: {opcode, rs, rt, imm16}.
- J-type: {opcode, imm26}.
- Fields not used by a format are ignored.
REQ-017 FSM states IDLE, RUN, DONE; reset state is IDLE.
REQ-018 Transitions:
- IDLE -> RUN on start with num_words != 0.
- start with num_words == 0: IDLE -> DONE, done pulses next cycle, no words are emitted.
- DONE -> IDLE unconditionally after one cycle.
REQ-019 in_ready = (state == RUN) && (words_left_to_accept != 0) && (!out_valid || out_ready); this gives a one-entry output register with pass-through readiness.
REQ-020 Input acceptance: a tuple is accepted when in_valid && in_ready. The packed word and current address are registered into out_data/out_addr, and out_valid is set the next cycle (latency 1).
REQ-021 out_data and out_addr hold stable while out_valid && !out_ready.
REQ-022 The address counter starts at base_addr and increments by 4 per accepted word, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-023 Illegal fmt (3): the tuple is accepted and consumed, fmt_err is set, no word is emitted, the address does not advance, and it does not count toward num_words.
REQ-024 Output completion: out_valid clears on out_valid && out_ready unless a new word is loaded in the same cycle, in which case it stays high.
REQ-025 When the num_words-th word completes its out handshake: RUN -> DONE and done pulses for one cycle.
REQ-026 start while in RUN or DONE is ignored.
REQ-027 in_valid outside RUN is not accepted (in_ready = 0).

Reset
REQ-028 On a clk edge with rst_n = 0:
- state = IDLE
- out_valid = 0, out_data = 0, out_addr = 0
- busy = 0, done = 0, fmt_err = 0
- counters = 0
REQ-029 Reset asserted mid-RUN abandons the load; a held output word is discarded without handshake.

Structure
REQ-030 The shared package holds:
- format codes FMT_R, FMT_I, FMT_J, FMT_ILL;
- the state enum;
- field-position constants (OPC_LSB = 26, RS_LSB = 21, RT_LSB = 16, RD_LSB = 11, SHAMT_LSB = 6).
REQ-031 A combinational sub-module instr_field_pack performs the format-to-word packing; the FSM, counters and output register stay in instr_encoder.

Verification
REQ-032 R-type: start, base 0x00400000, num_words = 1; fmt 0, opcode 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20 -> out_data 0x00221820, out_addr 0x00400000, done one cycle after the handshake.
REQ-033 I then J: num_words = 2.
- I-type: opcode 8, rs 0, rt 8, imm16 0x0005 -> 0x20080005 at 0x00400000.
- J-type: opcode 2, imm26 0x0100000 -> 0x08100000 at 0x00400004.
REQ-034 Backpressure: out_ready held low for 5 cycles -> out_data/out_addr stable, in_ready = 0, and no word is lost or duplicated.
REQ-035 Illegal fmt 3 between two legal tuples -> fmt_err = 1, exactly 2 words emitted at consecutive addresses.
REQ-036 Wrap: base 0xFFFFFFFC, num_words = 2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-037 Reset mid-RUN with out_valid = 1 -> next cycle out_valid = 0, busy = 0, state IDLE; a subsequent start runs cleanly.
